// File: rtl/yuv444_to_yuv422.sv
// -----------------------------------------------------------------------------
// yuv444_to_yuv422
//
// Converts a 4:4:4 YUV token stream into a 4:2:2 stream of {Y, C} words,
// where C is U on even pixels and V on odd pixels.
//
// Two chroma modes are available, chosen per pixel pair:
//   enable=1 : averaged decimation. The even pixel is held and nothing is
//              emitted. The odd pixel then emits two words together:
//              {Y0, avg(U0,U1)} and {Y1, avg(V0,V1)}.
//   enable=0 : plain subsampling. Each pixel emits one word on the cycle it
//              is accepted.
// Control (non-image) tokens pass through unchanged as {Y, U}. A control
// token that arrives while an even pixel is held first flushes that pixel
// as {Y0, U0}.
//
// A small output queue absorbs the two-word burst. One entry leaves per
// cycle. When the queue is empty, a freshly pushed word goes straight to
// the output registers, so single words appear one cycle after acceptance.
//
// Ports
//   clk         sole clock, rising edge
//   resetb      asynchronous active-low reset
//   enable      1 = averaged chroma, 0 = subsampled chroma
//   dvi         input token valid
//   dtypei      input token type
//   yi          unsigned luma
//   ui, vi      signed chroma
//   meta_datai  sideband data travelling with the token
//   dvo         output token valid
//   dtypeo      output token type
//   datao       packed output word {Y, C}
//   meta_datao  sideband data of the output token
//   overflow    sticky flag, set when queued words had to be dropped
// -----------------------------------------------------------------------------

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_IMG
`define DTYPE_IMG 4'h1
`endif

module yuv444_to_yuv422 #(
    parameter int PIXEL_WIDTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      resetb,
    input  logic                      enable,
    input  logic                      dvi,
    input  logic [`DTYPE_WIDTH-1:0]   dtypei,
    input  logic [PIXEL_WIDTH-1:0]    yi,
    input  logic [PIXEL_WIDTH-1:0]    ui,
    input  logic [PIXEL_WIDTH-1:0]    vi,
    input  logic [15:0]               meta_datai,
    output logic                      dvo,
    output logic [`DTYPE_WIDTH-1:0]   dtypeo,
    output logic [2*PIXEL_WIDTH-1:0]  datao,
    output logic [15:0]               meta_datao,
    output logic                      overflow
);

    localparam int DTW = `DTYPE_WIDTH;
    localparam int PW  = PIXEL_WIDTH;
    localparam int DW  = 2 * PIXEL_WIDTH;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef struct packed {
        logic [DTW-1:0] dtype;
        logic [DW-1:0]  data;
        logic [15:0]    meta;
    } entry_t;

    // Rounded mean of two signed samples, evaluated one bit wider so the
    // sum cannot wrap; bits [PW:1] are the arithmetic shift right by one.
    function automatic logic [PW-1:0] chroma_avg(input logic [PW-1:0] a,
                                                 input logic [PW-1:0] b);
        logic [PW:0] sum;
        sum = {a[PW-1], a} + {b[PW-1], b} + (PW+1)'(1);
        return sum[PW:1];
    endfunction

    // Pair tracking and even-pixel hold registers
    logic           r_phase;
    logic           r_pair_avg;
    logic [PW-1:0]  r_hold_y;
    logic [PW-1:0]  r_hold_u;
    logic [PW-1:0]  r_hold_v;
    logic [DTW-1:0] r_hold_dtype;
    logic [15:0]    r_hold_meta;

    // Output queue
    entry_t         r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic           r_overflow;

    logic           w_pix_acc;
    logic           w_ctl_acc;
    logic           w_held;
    logic [1:0]     w_n_push;
    entry_t         w_push0;
    entry_t         w_push1;
    logic           w_have_stored;
    logic           w_out_valid;
    entry_t         w_out_entry;
    entry_t         w_store0;
    entry_t         w_store1;
    logic [1:0]     w_n_store;
    logic [CW:0]    w_space;
    logic           w_drop;
    logic [1:0]     w_n_wr;

    assign w_pix_acc = dvi && (dtypei == `DTYPE_IMG);
    assign w_ctl_acc = dvi && (dtypei != `DTYPE_IMG);
    assign w_held    = r_phase && r_pair_avg;

    // Decide which words this cycle's token produces, in output order.
    always_comb begin
        w_n_push = 2'd0;
        w_push0  = '{dtype: dtypei, data: {yi, ui}, meta: meta_datai};
        w_push1  = '{dtype: dtypei, data: {yi, ui}, meta: meta_datai};
        if (w_pix_acc) begin
            if (!r_phase) begin
                if (!enable) begin
                    w_n_push = 2'd1;
                end
            end else if (r_pair_avg) begin
                w_n_push = 2'd2;
                w_push0  = '{dtype: r_hold_dtype,
                             data:  {r_hold_y, chroma_avg(r_hold_u, ui)},
                             meta:  r_hold_meta};
                w_push1  = '{dtype: dtypei,
                             data:  {yi, chroma_avg(r_hold_v, vi)},
                             meta:  meta_datai};
            end else begin
                w_n_push = 2'd1;
                w_push0  = '{dtype: dtypei, data: {yi, vi}, meta: meta_datai};
            end
        end else if (w_ctl_acc) begin
            if (w_held) begin
                w_n_push = 2'd2;
                w_push0  = '{dtype: r_hold_dtype,
                             data:  {r_hold_y, r_hold_u},
                             meta:  r_hold_meta};
            end else begin
                w_n_push = 2'd1;
            end
        end
    end

    // Queue bookkeeping. The head goes to the output every cycle something is
    // available; with nothing stored, the first new word bypasses storage.
    always_comb begin
        w_have_stored = (r_count != '0);
        w_out_valid   = w_have_stored || (w_n_push != 2'd0);
        w_out_entry   = w_have_stored ? r_mem[r_rd_ptr] : w_push0;
        if (w_have_stored) begin
            w_store0  = w_push0;
            w_store1  = w_push1;
            w_n_store = w_n_push;
        end else begin
            w_store0  = w_push1;
            w_store1  = w_push1;
            w_n_store = (w_n_push == 2'd2) ? 2'd1 : 2'd0;
        end
        w_space = (CW+1)'(FIFO_DEPTH) - {1'b0, r_count}
                  + {{CW{1'b0}}, w_have_stored};
        w_drop  = ({{(CW-1){1'b0}}, w_n_store} > w_space);
        w_n_wr  = w_drop ? w_space[1:0] : w_n_store;
    end

    // Phase toggles on pixels, returns to even on control tokens; the
    // even pixel's enable decides the mode for the whole pair.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_phase      <= 1'b0;
            r_pair_avg   <= 1'b0;
            r_hold_y     <= '0;
            r_hold_u     <= '0;
            r_hold_v     <= '0;
            r_hold_dtype <= '0;
            r_hold_meta  <= '0;
        end else if (w_pix_acc) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_pair_avg   <= enable;
                r_hold_y     <= yi;
                r_hold_u     <= ui;
                r_hold_v     <= vi;
                r_hold_dtype <= dtypei;
                r_hold_meta  <= meta_datai;
            end
        end else if (w_ctl_acc) begin
            r_phase    <= 1'b0;
            r_pair_avg <= 1'b0;
        end
    end

    // Queue pointers, occupancy, sticky overflow and registered outputs.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            dvo        <= 1'b0;
            dtypeo     <= '0;
            datao      <= '0;
            meta_datao <= '0;
        end else begin
            dvo <= w_out_valid;
            if (w_out_valid) begin
                dtypeo     <= w_out_entry.dtype;
                datao      <= w_out_entry.data;
                meta_datao <= w_out_entry.meta;
            end
            if (w_have_stored) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_wr_ptr <= r_wr_ptr + AW'(w_n_wr);
            r_count  <= r_count - CW'(w_have_stored) + CW'(w_n_wr);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Queue storage needs no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (w_n_wr != 2'd0) begin
            r_mem[r_wr_ptr] <= w_store0;
        end
        if (w_n_wr == 2'd2) begin
            r_mem[r_wr_ptr + AW'(1)] <= w_store1;
        end
    end

    assign overflow = r_overflow;

endmodule

// File: tb/tb_yuv444_to_yuv422.sv
// -----------------------------------------------------------------------------
// tb_yuv444_to_yuv422
//
// Drives directed scenarios and random token traffic into yuv444_to_yuv422.
// A reference model keeps the expected output words in a queue. Each cycle,
// the DUT output must equal the front of that queue, or must be idle when the
// queue is empty.
// -----------------------------------------------------------------------------

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_IMG
`define DTYPE_IMG 4'h1
`endif

module tb_yuv444_to_yuv422;

    localparam logic [3:0] IMG  = `DTYPE_IMG;
    localparam logic [3:0] CTRL = 4'h3;

    logic        clk;
    logic        resetb;
    logic        enable;
    logic        dvi;
    logic [3:0]  dtypei;
    logic [7:0]  yi;
    logic [7:0]  ui;
    logic [7:0]  vi;
    logic [15:0] meta_datai;
    logic        dvo;
    logic [3:0]  dtypeo;
    logic [15:0] datao;
    logic [15:0] meta_datao;
    logic        overflow;

    typedef struct packed {
        logic [3:0]  dt;
        logic [15:0] data;
        logic [15:0] meta;
    } expWord_t;

    expWord_t    expQ[$];
    int          nChecks;
    int          nPass;

    // Model state: which half of a pair comes next, and the stored even pixel.
    logic        mOdd;
    logic        mAvg;
    logic [7:0]  hY;
    logic [7:0]  hU;
    logic [7:0]  hV;
    logic [3:0]  hDt;
    logic [15:0] hMeta;

    yuv444_to_yuv422 #(.PIXEL_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .enable     (enable),
        .dvi        (dvi),
        .dtypei     (dtypei),
        .yi         (yi),
        .ui         (ui),
        .vi         (vi),
        .meta_datai (meta_datai),
        .dvo        (dvo),
        .dtypeo     (dtypeo),
        .datao      (datao),
        .meta_datao (meta_datao),
        .overflow   (overflow)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a broken run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        if (observed === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Rounded mean of two signed 8-bit values, rounding halves upward.
    function automatic logic [7:0] avgChroma(input logic [7:0] a, input logic [7:0] b);
        int s;
        int r;
        s = int'($signed(a)) + int'($signed(b)) + 1;
        r = (s < 0) ? (s - 1) / 2 : s / 2;
        return r[7:0];
    endfunction

    task automatic pushExp(input logic [3:0] dt, input logic [15:0] data,
                           input logic [15:0] meta);
        expWord_t e;
        e.dt   = dt;
        e.data = data;
        e.meta = meta;
        expQ.push_back(e);
    endtask

    task automatic checkCycle();
        expWord_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("dvo", 64'(dvo), 64'd1);
            checkOutput("datao", 64'(datao), 64'(e.data));
            checkOutput("dtypeo", 64'(dtypeo), 64'(e.dt));
            checkOutput("meta_datao", 64'(meta_datao), 64'(e.meta));
        end else begin
            checkOutput("dvo_idle", 64'(dvo), 64'd0);
        end
        checkOutput("overflow", 64'(overflow), 64'd0);
    endtask

    // Drive one cycle of input, update the model, then check the DUT output.
    task automatic applyStimulus(input logic dv, input logic [3:0] dt,
                                 input logic [7:0] y, input logic [7:0] u,
                                 input logic [7:0] v, input logic [15:0] meta,
                                 input logic en);
        dvi        = dv;
        dtypei     = dt;
        yi         = y;
        ui         = u;
        vi         = v;
        meta_datai = meta;
        enable     = en;
        if (dv) begin
            if (dt == IMG) begin
                if (!mOdd) begin
                    mAvg = en;
                    if (en) begin
                        hY = y; hU = u; hV = v; hDt = dt; hMeta = meta;
                    end else begin
                        pushExp(dt, {y, u}, meta);
                    end
                    mOdd = 1'b1;
                end else begin
                    if (mAvg) begin
                        pushExp(hDt, {hY, avgChroma(hU, u)}, hMeta);
                        pushExp(dt, {y, avgChroma(hV, v)}, meta);
                    end else begin
                        pushExp(dt, {y, v}, meta);
                    end
                    mOdd = 1'b0;
                end
            end else begin
                if (mOdd && mAvg) begin
                    pushExp(hDt, {hY, hU}, hMeta);
                end
                pushExp(dt, {y, u}, meta);
                mOdd = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        checkCycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, IMG, 8'($urandom), 8'($urandom), 8'($urandom),
                          16'($urandom), 1'($urandom));
        end
    endtask

    task automatic doReset();
        resetb = 1'b0;
        #1;
        checkOutput("rst_dvo", 64'(dvo), 64'd0);
        checkOutput("rst_datao", 64'(datao), 64'd0);
        checkOutput("rst_dtypeo", 64'(dtypeo), 64'd0);
        checkOutput("rst_meta", 64'(meta_datao), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        expQ.delete();
        mOdd = 1'b0;
        mAvg = 1'b0;
        @(posedge clk);
        #1;
        resetb = 1'b1;
    endtask

    initial begin
        nChecks    = 0;
        nPass      = 0;
        mOdd       = 1'b0;
        mAvg       = 1'b0;
        hY = '0; hU = '0; hV = '0; hDt = '0; hMeta = '0;
        resetb     = 1'b1;
        enable     = 1'b0;
        dvi        = 1'b0;
        dtypei     = '0;
        yi         = '0;
        ui         = '0;
        vi         = '0;
        meta_datai = '0;
        #2;
        doReset();
        idle(2);

        // Averaged pair: {10,0} then {20,6}
        applyStimulus(1'b1, IMG, 8'd10, 8'hFD, 8'd4, 16'h1111, 1'b1);
        applyStimulus(1'b1, IMG, 8'd20, 8'd2, 8'd7, 16'h2222, 1'b1);
        checkOutput("r033_even", 64'(datao), 64'h0A00);
        applyStimulus(1'b0, IMG, 8'd0, 8'd0, 8'd0, 16'h0, 1'b1);
        checkOutput("r033_odd", 64'(datao), 64'h1406);

        // Chroma extremes average without wrapping
        applyStimulus(1'b1, IMG, 8'd1, 8'd127, 8'd0, 16'h3, 1'b1);
        applyStimulus(1'b1, IMG, 8'd2, 8'd127, 8'd0, 16'h4, 1'b1);
        checkOutput("r034_pos", 64'(datao[7:0]), 64'h7F);
        applyStimulus(1'b1, IMG, 8'd3, 8'h80, 8'h80, 16'h5, 1'b1);
        applyStimulus(1'b1, IMG, 8'd4, 8'h80, 8'h80, 16'h6, 1'b1);
        checkOutput("r034_neg", 64'(datao[7:0]), 64'h80);
        idle(2);

        // Row of three pixels then a row-end control token (orphan flush)
        applyStimulus(1'b1, IMG, 8'd30, 8'd8, 8'd9, 16'hA0, 1'b1);
        applyStimulus(1'b1, IMG, 8'd31, 8'd10, 8'd11, 16'hA1, 1'b1);
        applyStimulus(1'b1, IMG, 8'd32, 8'd12, 8'd13, 16'hA2, 1'b1);
        applyStimulus(1'b1, CTRL, 8'd40, 8'd41, 8'd42, 16'hA3, 1'b1);
        idle(3);

        // Subsampling, enable raised mid-pair
        applyStimulus(1'b1, IMG, 8'd50, 8'd5, 8'd9, 16'hB0, 1'b0);
        checkOutput("r036_even", 64'(datao[7:0]), 64'd5);
        applyStimulus(1'b1, IMG, 8'd51, 8'd1, 8'hFE, 16'hB1, 1'b1);
        checkOutput("r036_odd", 64'(datao[7:0]), 64'hFE);
        idle(2);

        // Pair split by idle cycles
        applyStimulus(1'b1, IMG, 8'd60, 8'hF0, 8'd20, 16'hC0, 1'b1);
        idle(3);
        applyStimulus(1'b1, IMG, 8'd61, 8'd3, 8'hEC, 16'hC1, 1'b0);
        idle(2);

        // Reset with a word still queued
        applyStimulus(1'b1, IMG, 8'd70, 8'd1, 8'd2, 16'hD0, 1'b1);
        applyStimulus(1'b1, IMG, 8'd71, 8'd3, 8'd4, 16'hD1, 1'b1);
        doReset();
        idle(3);

        // Reset while an even pixel is held; next pixel starts a new pair
        applyStimulus(1'b1, IMG, 8'd80, 8'd5, 8'd6, 16'hE0, 1'b1);
        doReset();
        idle(2);
        applyStimulus(1'b1, IMG, 8'd81, 8'd7, 8'd8, 16'hE1, 1'b1);
        applyStimulus(1'b1, IMG, 8'd82, 8'd9, 8'd10, 16'hE2, 1'b1);
        idle(2);

        // Random traffic
        begin
            logic en;
            en = 1'b1;
            for (int i = 0; i < 600; i++) begin
                logic       dv;
                logic [3:0] dt;
                dv = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 9) < 8) begin
                    dt = IMG;
                end else begin
                    dt = 4'($urandom);
                    if (dt == IMG) dt = 4'h0;
                end
                if ($urandom_range(0, 7) == 0) en = ~en;
                applyStimulus(dv, dt, 8'($urandom), 8'($urandom), 8'($urandom),
                              16'($urandom), en);
            end
        end
        idle(4);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
